// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mul_share_arbiter
// Description : Round-robin sharing of one multi-cycle multiplier among
//               NUM_REQ req/ack clients; all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       client_req,
  input  logic [NUM_REQ*WIDTH-1:0] client_a,
  input  logic [NUM_REQ*WIDTH-1:0] client_b,
  output logic [NUM_REQ-1:0]       client_ack,
  output logic [WIDTH-1:0]         client_out,
  output logic                     busy,
  output logic                     mul_req,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [WIDTH-1:0]         mul_out,
  input  logic                     mul_ack
);

  localparam int                 c_IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [c_IDX_W:0]   c_NUM_REQ = (c_IDX_W+1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] c_ONE_HOT = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [c_IDX_W-1:0]   r_rr_ptr;
  logic [c_IDX_W-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_client_ack;
  logic [WIDTH-1:0]     r_client_out;
  logic                 r_busy;
  logic                 r_mul_req;
  logic [WIDTH-1:0]     r_mul_a;
  logic [WIDTH-1:0]     r_mul_b;

  logic                 w_found;
  logic [c_IDX_W-1:0]   w_winner;
  logic [c_IDX_W:0]     w_cand;
  logic [c_IDX_W:0]     w_grant_inc;
  logic [c_IDX_W-1:0]   w_rr_next;

  // Round-robin search: first requesting client at or above r_rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_cand   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (c_IDX_W+1)'(k);
      if (w_cand >= c_NUM_REQ) begin
        w_cand = w_cand - c_NUM_REQ;
      end
      if (!w_found && client_req[w_cand[c_IDX_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_cand[c_IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_grant_inc = {1'b0, r_grant} + {{c_IDX_W{1'b0}}, 1'b1};
    w_rr_next   = (w_grant_inc == c_NUM_REQ) ? '0 : w_grant_inc[c_IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A mul_ack outside WAIT is stale and never moves the FSM.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_WAIT;
      S_WAIT:  if (mul_ack) w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_grant      <= '0;
      r_client_ack <= '0;
      r_client_out <= '0;
      r_busy       <= 1'b0;
      r_mul_req    <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
    end else begin
      r_busy       <= (w_state_next != S_IDLE);
      r_mul_req    <= (w_state_next == S_ISSUE);
      r_client_ack <= '0;
      r_client_out <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_winner;
            r_mul_a <= client_a[int'(w_winner)*WIDTH +: WIDTH];
            r_mul_b <= client_b[int'(w_winner)*WIDTH +: WIDTH];
          end
        end
        S_WAIT: begin
          if (mul_ack) begin
            r_client_out <= mul_out;
            r_client_ack <= c_ONE_HOT << r_grant;
          end
        end
        S_RESP: begin
          r_rr_ptr <= w_rr_next;
        end
        default: ;
      endcase
    end
  end

  assign client_ack = r_client_ack;
  assign client_out = r_client_out;
  assign busy       = r_busy;
  assign mul_req    = r_mul_req;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_share_arbiter
// Description : Directed bench with expected-result queue and ack monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;

  typedef struct {
    int          idx;
    logic [31:0] val;
  } exp_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       client_req;
  logic [NUM_REQ*WIDTH-1:0] client_a;
  logic [NUM_REQ*WIDTH-1:0] client_b;
  logic [NUM_REQ-1:0]       client_ack;
  logic [WIDTH-1:0]         client_out;
  logic                     busy;
  logic                     mul_req;
  logic [WIDTH-1:0]         mul_a;
  logic [WIDTH-1:0]         mul_b;
  logic [WIDTH-1:0]         mul_out;
  logic                     mul_ack;

  exp_t        exp_q[$];
  int          n_tests;
  int          n_fail;
  int          stale_cnt;
  bit          reload_en[NUM_REQ];
  logic [31:0] reload_a[NUM_REQ];

  always #5 clk = ~clk;

  mul_share_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .client_req (client_req),
    .client_a   (client_a),
    .client_b   (client_b),
    .client_ack (client_ack),
    .client_out (client_out),
    .busy       (busy),
    .mul_req    (mul_req),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_out    (mul_out),
    .mul_ack    (mul_ack)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_client(input int i, input logic [31:0] a, input logic [31:0] b);
    client_a[i*32 +: 32] = a;
    client_b[i*32 +: 32] = b;
    client_req[i]        = 1'b1;
  endtask

  task automatic expect_res(input int i, input logic [31:0] v);
    exp_t e;
    e.idx = i;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && !busy && client_req == '0) && n < 500);
    chk({name, "_done"}, 64'(n < 500), 64'd1);
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    client_req = '0;
    client_a   = '0;
    client_b   = '0;
    n_tests    = 0;
    n_fail     = 0;
    stale_cnt  = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      reload_en[i] = 1'b0;
      reload_a[i]  = '0;
    end

    fork
      begin : mul_model
        bit          pend;
        int          cnt;
        int          stale_done;
        logic [31:0] prod;
        pend = 1'b0; cnt = 0; stale_done = 0; prod = '0;
        mul_ack = 1'b0;
        mul_out = '0;
        forever begin
          @(posedge clk); #1;
          mul_ack = 1'b0;
          if (rst) begin
            pend = 1'b0;
          end else if (stale_cnt != stale_done) begin
            stale_done = stale_cnt;
            mul_ack    = 1'b1;
            mul_out    = 32'hDEAD_BEEF;
          end else if (pend) begin
            if (cnt == 0) begin
              mul_ack = 1'b1;
              mul_out = prod;
              pend    = 1'b0;
            end else begin
              cnt--;
            end
          end
          if (mul_req && !rst) begin
            pend = 1'b1;
            cnt  = 2;
            prod = mul_a * mul_b;
          end
        end
      end
      begin : clients
        forever begin
          @(posedge clk); #1;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (client_ack[i]) begin
              if (reload_en[i]) begin
                reload_en[i]         = 1'b0;
                client_a[i*32 +: 32] = reload_a[i];
              end else begin
                client_req[i] = 1'b0;
              end
            end
          end
        end
      end
      begin : monitor
        int   cyc;
        int   mack_cyc;
        exp_t e;
        cyc = 0; mack_cyc = -10;
        forever begin
          @(negedge clk);
          cyc++;
          if (mul_ack) mack_cyc = cyc;
          if (client_ack != '0) begin
            if (exp_q.size() == 0) begin
              chk("unexpected_ack", 64'(client_ack), 64'd0);
            end else begin
              e = exp_q.pop_front();
              chk("ack_onehot", 64'(client_ack), 64'(4'b0001 << e.idx));
              chk("result", 64'(client_out), 64'(e.val));
              chk("ack_latency", 64'(cyc - mack_cyc), 64'd1);
            end
          end
        end
      end
    join_none

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(client_ack), 64'd0);
    chk("rst_out", 64'(client_out), 64'd0);
    chk("rst_mul_req", 64'(mul_req), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // clients 0 and 2 together: 0 first, then 2; pointer lands on 3
    @(posedge clk); #2;
    expect_res(0, 32'd8);
    expect_res(2, 32'd36);
    set_client(0, 32'd2, 32'd4);
    set_client(2, 32'd6, 32'd6);
    wait_done("two_req");

    // pointer at 3: client 3 beats client 0
    @(posedge clk); #2;
    expect_res(3, 32'd20);
    expect_res(0, 32'd81);
    set_client(0, 32'd9, 32'd9);
    set_client(3, 32'd4, 32'd5);
    wait_done("rr_ptr3");

    // single request 3*5 with cycle-level timing
    @(posedge clk); #2;
    expect_res(0, 32'd15);
    set_client(0, 32'd3, 32'd5);
    @(negedge clk);
    chk("single_idle_mul_req", 64'(mul_req), 64'd0);
    chk("single_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("single_issue_mul_req", 64'(mul_req), 64'd1);
    chk("single_issue_busy", 64'(busy), 64'd1);
    chk("single_mul_a", 64'(mul_a), 64'd3);
    chk("single_mul_b", 64'(mul_b), 64'd5);
    @(negedge clk);
    chk("single_wait_mul_req", 64'(mul_req), 64'd0);
    n = 0;
    while (client_ack == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("single_ack_seen", 64'(n < 50), 64'd1);
    @(negedge clk);
    chk("single_busy_after", 64'(busy), 64'd0);
    wait_done("single");

    // truncation and zero operand
    @(posedge clk); #2;
    expect_res(2, 32'hFFFF_FFFE);
    set_client(2, 32'hFFFF_FFFF, 32'd2);
    wait_done("trunc");
    @(posedge clk); #2;
    expect_res(3, 32'd0);
    set_client(3, 32'd0, 32'd12345);
    wait_done("zero");

    // all four held; client 0 re-requests with new operands and is ranked last
    @(posedge clk); #2;
    reload_en[0] = 1'b1;
    reload_a[0]  = 32'd10;
    expect_res(0, 32'd7);
    expect_res(1, 32'd14);
    expect_res(2, 32'd21);
    expect_res(3, 32'd28);
    expect_res(0, 32'd70);
    for (int i = 0; i < NUM_REQ; i++) set_client(i, 32'(i + 1), 32'd7);
    wait_done("all_four");

    // stale mul_ack while idle
    @(posedge clk); #2;
    stale_cnt++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stale_idle_busy", 64'(busy), 64'd0);
      chk("stale_idle_ack", 64'(client_ack), 64'd0);
    end

    // reset while waiting on the multiplier
    @(posedge clk); #2;
    set_client(1, 32'd7, 32'd3);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mul_req && n < 20);
    chk("abort_issue_seen", 64'(n < 20), 64'd1);
    @(posedge clk); #2;
    rst        = 1'b1;
    client_req = '0;
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ack", 64'(client_ack), 64'd0);
    chk("abort_mul_req", 64'(mul_req), 64'd0);
    chk("abort_mul_a", 64'(mul_a), 64'd0);
    @(posedge clk); #2;
    stale_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_stale_ack", 64'(client_ack), 64'd0);
      chk("abort_stale_busy", 64'(busy), 64'd0);
    end
    @(posedge clk); #2;
    expect_res(1, 32'd21);
    set_client(1, 32'd7, 32'd3);
    wait_done("after_abort");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
